instruction_fetch_decode: RTL and testbench
===========================================

# instruction_fetch_decode

Fetch/decode front end that sits directly upstream of the instruction ROM and downstream of it at once. It owns the program counter, drives the ROM address, registers the 28-bit instruction the ROM returns, and splits it into opcode and operand fields for the execute stage. It honours a downstream stall and a branch redirect. After every IMUL it inserts a fixed number of bubble cycles so the multi-cycle multiplier can finish.

## Interface
Parameters:
- IMUL_OPCODE, default 4'd9 — opcode value (bits [27:24]) that identifies IMUL; set from the shared definitions at integration.
- IMUL_LATENCY, default 4 — total execute cycles of IMUL, legal range 1..15; bubbles inserted = IMUL_LATENCY-1.

Ports:
- Clock  in  1  — single clock, all state updates on rising edge.
- Reset  in  1  — synchronous, active-high.
- oAddress  out  16  — ROM address (current PC), combinational from the PC register.
- iInstruction  in  28  — ROM data for oAddress, combinational from the ROM.
- iStall  in  1  — downstream did not accept the current issued instruction; hold.
- iBranchTaken  in  1  — redirect request from execute.
- iBranchTarget  in  16  — new PC when iBranchTaken=1.
- oValid  out  1  — decoded fields carry a real instruction this cycle.
- oInstructionAddress  out  16  — address the issued instruction was fetched from.
- oOperation  out  4  — iInstruction[27:24].
- oDestination  out  8  — iInstruction[23:16].
- oSourceA  out  8  — iInstruction[15:8].
- oSourceB  out  8  — iInstruction[7:0].
- oImmediate  out  16  — iInstruction[15:0]; same bits as SourceA:SourceB.
- oBusy  out  1  — 1 while in IMUL_WAIT.

## Operation
- State: PC (16 b), FSM {FETCH, IMUL_WAIT}, wait counter (4 b), registered output fields.
- Reset (edge with Reset=1): PC=0, FSM=FETCH, counter=0, oValid=0, all field outputs and oInstructionAddress=0, oBusy=0. Reset overrides every other input.
- Priority when not in reset: iBranchTaken > IMUL_WAIT countdown > iStall > normal issue.
- Branch, any state: PC<=iBranchTarget, oValid<=0, FSM<=FETCH, counter<=0. Field outputs hold their old values.
- FETCH with iStall=1: PC, oValid, fields and oInstructionAddress all hold.
- FETCH normal issue:
  - fields<=slices of iInstruction, oInstructionAddress<=PC, oValid<=1, PC<=PC+1.
  - If the opcode equals IMUL_OPCODE and IMUL_LATENCY>1: FSM<=IMUL_WAIT, counter<=IMUL_LATENCY-1.
- IMUL_WAIT:
  - oValid<=0 every edge, PC holds, iStall ignored.
  - If counter==1: FSM<=FETCH, counter<=0. Otherwise counter decrements.
- PC arithmetic: modulo 2^16; 16'hFFFF+1 = 16'h0000, with no flag.
- oBusy = (FSM==IMUL_WAIT).

## Timing
- Fetch-to-issue latency is 1 cycle: the address is on oAddress in cycle n, and its fields plus oValid=1 are visible after edge n+1.
- Sustained throughput is 1 instruction/cycle with no stall and no IMUL.
- IMUL issued at edge k: oValid=0 after edges k+1..k+IMUL_LATENCY-1. The next instruction (at IMUL address+1) issues at edge k+IMUL_LATENCY.
- Branch asserted in cycle m: oValid=0 after edge m. The target instruction issues at edge m+1 (barring stall).
- Stall asserted for N cycles: outputs are frozen for N edges. Issue resumes on the first edge with iStall=0.
- Reset released in cycle r: oAddress=0 during r, and the first issue happens at edge r+1.

## Test plan
- Reset, then run a ROM model holding NOP, STO R1 #10, STO R2 #10, NOP (opcode≠IMUL) -> addresses 0,1,2,3 issue on 4 consecutive edges, oValid=1 throughout. For STO R1 #10: oDestination=R1, oImmediate=16'd10.
- ROM word 4 = IMUL R3,R1,R2, IMUL_LATENCY=4 -> issue at edge k with oDestination=R3, oSourceA=R1, oSourceB=R2. Then oValid=0 and oBusy=1 for 3 cycles, and address 5 issues at edge k+4.
- iStall=1 for 3 cycles while address 2 is issued -> oInstructionAddress stays 2, oAddress stays 3; address 3 issues on the first unstalled edge.
- iBranchTaken=1 with target 16'h0010, with iStall=1 at the same time -> next edge oValid=0 and oAddress=16'h0010; following edge issues address 16'h0010.
- Branch to 16'hFFFF with non-IMUL code -> issues 16'hFFFF then 16'h0000 on consecutive edges.
- Reset asserted during IMUL_WAIT (counter=2) -> next edge oValid=0, oBusy=0, oAddress=0; first issue is address 0 one edge after Reset drops.

Source files
------------

// File: rtl/instruction_fetch_decode.sv
// Fetch/decode front end: owns the PC, registers the ROM word into decoded
// fields, and holds issue for IMUL_LATENCY-1 bubble cycles after every IMUL.
module instruction_fetch_decode #(
  parameter logic [3:0]  IMUL_OPCODE  = 4'd9,
  parameter int unsigned IMUL_LATENCY = 4
) (
  input  logic        Clock,
  input  logic        Reset,
  output logic [15:0] oAddress,
  input  logic [27:0] iInstruction,
  input  logic        iStall,
  input  logic        iBranchTaken,
  input  logic [15:0] iBranchTarget,
  output logic        oValid,
  output logic [15:0] oInstructionAddress,
  output logic [3:0]  oOperation,
  output logic [7:0]  oDestination,
  output logic [7:0]  oSourceA,
  output logic [7:0]  oSourceB,
  output logic [15:0] oImmediate,
  output logic        oBusy
);

  localparam logic [3:0] LP_WAIT_CNT   = 4'(IMUL_LATENCY - 1);
  localparam bit         LP_NEEDS_WAIT = (IMUL_LATENCY > 1);

  typedef enum logic [0:0] {
    S_FETCH     = 1'b0,
    S_IMUL_WAIT = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic [15:0] r_pc_p0;
  logic [15:0] w_pc_nxt;
  logic        r_vld_p1;
  logic        w_vld_nxt;
  logic        w_issue;
  logic        w_is_imul;

  logic [15:0] r_iaddr_p1;
  logic [3:0]  r_op_p1;
  logic [7:0]  r_dst_p1;
  logic [7:0]  r_srca_p1;
  logic [7:0]  r_srcb_p1;

  assign w_is_imul = (iInstruction[27:24] == IMUL_OPCODE);

  // Stage p0: PC / FSM next state. Branch beats the IMUL countdown, which beats stall.
  always_comb begin
    w_pc_nxt    = r_pc_p0;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_vld_nxt   = r_vld_p1;
    w_issue     = 1'b0;
    if (iBranchTaken) begin
      w_pc_nxt    = iBranchTarget;
      w_vld_nxt   = 1'b0;
      w_state_nxt = S_FETCH;
      w_cnt_nxt   = 4'd0;
    end else if (r_state == S_IMUL_WAIT) begin
      w_vld_nxt = 1'b0;
      if (r_cnt == 4'd1) begin
        w_state_nxt = S_FETCH;
        w_cnt_nxt   = 4'd0;
      end else begin
        w_cnt_nxt = r_cnt - 4'd1;
      end
    end else if (!iStall) begin
      w_issue   = 1'b1;
      w_vld_nxt = 1'b1;
      w_pc_nxt  = r_pc_p0 + 16'd1;
      if (w_is_imul && LP_NEEDS_WAIT) begin
        w_state_nxt = S_IMUL_WAIT;
        w_cnt_nxt   = LP_WAIT_CNT;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_pc_p0  <= 16'd0;
      r_state  <= S_FETCH;
      r_cnt    <= 4'd0;
      r_vld_p1 <= 1'b0;
    end else begin
      r_pc_p0  <= w_pc_nxt;
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_vld_p1 <= w_vld_nxt;
    end
  end

  // Stage p1: decoded fields, loaded only on an actual issue.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_iaddr_p1 <= 16'd0;
      r_op_p1    <= 4'd0;
      r_dst_p1   <= 8'd0;
      r_srca_p1  <= 8'd0;
      r_srcb_p1  <= 8'd0;
    end else if (w_issue) begin
      r_iaddr_p1 <= r_pc_p0;
      r_op_p1    <= iInstruction[27:24];
      r_dst_p1   <= iInstruction[23:16];
      r_srca_p1  <= iInstruction[15:8];
      r_srcb_p1  <= iInstruction[7:0];
    end
  end

  assign oAddress            = r_pc_p0;
  assign oValid              = r_vld_p1;
  assign oInstructionAddress = r_iaddr_p1;
  assign oOperation          = r_op_p1;
  assign oDestination        = r_dst_p1;
  assign oSourceA            = r_srca_p1;
  assign oSourceB            = r_srcb_p1;
  assign oImmediate          = {r_srca_p1, r_srcb_p1};
  assign oBusy               = (r_state == S_IMUL_WAIT);

endmodule

// File: tb/tb_instruction_fetch_decode.sv
// Bench for instruction_fetch_decode: directed vector table, hand-written
// branch-during-IMUL sequence, then random traffic against a behavioural model.
module tb_instruction_fetch_decode;

  localparam int LAT  = 4;
  localparam int IMUL = 9;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [15:0] oAddress;
  logic [27:0] iInstruction;
  logic        iStall = 1'b0;
  logic        iBranchTaken = 1'b0;
  logic [15:0] iBranchTarget = 16'd0;
  logic        oValid;
  logic [15:0] oInstructionAddress;
  logic [3:0]  oOperation;
  logic [7:0]  oDestination;
  logic [7:0]  oSourceA;
  logic [7:0]  oSourceB;
  logic [15:0] oImmediate;
  logic        oBusy;

  logic [27:0] rom [0:65535];
  assign iInstruction = rom[oAddress];

  instruction_fetch_decode #(.IMUL_OPCODE(4'd9), .IMUL_LATENCY(LAT)) dut (
    .Clock(Clock), .Reset(Reset), .oAddress(oAddress), .iInstruction(iInstruction),
    .iStall(iStall), .iBranchTaken(iBranchTaken), .iBranchTarget(iBranchTarget),
    .oValid(oValid), .oInstructionAddress(oInstructionAddress), .oOperation(oOperation),
    .oDestination(oDestination), .oSourceA(oSourceA), .oSourceB(oSourceB),
    .oImmediate(oImmediate), .oBusy(oBusy)
  );

  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: program counter, remaining bubble cycles, last issued word.
  int          m_pc;
  int          m_bubbles;
  bit          m_valid;
  int          m_iaddr;
  logic [27:0] m_word;

  typedef struct packed {
    logic        rst;
    logic        stall;
    logic        br;
    logic [15:0] tgt;
    logic        vld;
    logic [15:0] addr;
    logic [15:0] iaddr;
    logic        busy;
    logic [3:0]  op;
    logic [7:0]  dst;
    logic [15:0] imm;
  } vec_t;

  vec_t tbl [23];

  function automatic vec_t mk(input logic rst, input logic stall, input logic br,
                              input logic [15:0] tgt, input logic vld,
                              input logic [15:0] addr, input logic [15:0] iaddr,
                              input logic busy, input logic [3:0] op,
                              input logic [7:0] dst, input logic [15:0] imm);
    vec_t v;
    v.rst = rst; v.stall = stall; v.br = br; v.tgt = tgt; v.vld = vld;
    v.addr = addr; v.iaddr = iaddr; v.busy = busy; v.op = op; v.dst = dst; v.imm = imm;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic vld, input logic [15:0] addr,
                         input logic [15:0] iaddr, input logic busy, input logic [3:0] op,
                         input logic [7:0] dst, input logic [15:0] imm);
    chk({tag, ".oValid"}, 32'(oValid), 32'(vld));
    chk({tag, ".oAddress"}, 32'(oAddress), 32'(addr));
    chk({tag, ".oInstructionAddress"}, 32'(oInstructionAddress), 32'(iaddr));
    chk({tag, ".oBusy"}, 32'(oBusy), 32'(busy));
    chk({tag, ".oOperation"}, 32'(oOperation), 32'(op));
    chk({tag, ".oDestination"}, 32'(oDestination), 32'(dst));
    chk({tag, ".oSourceA"}, 32'(oSourceA), 32'(imm[15:8]));
    chk({tag, ".oSourceB"}, 32'(oSourceB), 32'(imm[7:0]));
    chk({tag, ".oImmediate"}, 32'(oImmediate), 32'(imm));
  endtask

  // Advance the model by one rising edge using the inputs held during the cycle.
  task automatic model_edge(input logic rst, input logic stall, input logic br,
                            input logic [15:0] tgt);
    if (rst) begin
      m_pc = 0; m_bubbles = 0; m_valid = 0; m_iaddr = 0; m_word = '0;
    end else if (br) begin
      m_pc = int'(tgt); m_valid = 0; m_bubbles = 0;
    end else if (m_bubbles > 0) begin
      m_valid = 0; m_bubbles = m_bubbles - 1;
    end else if (!stall) begin
      m_word  = rom[m_pc];
      m_iaddr = m_pc;
      m_valid = 1;
      m_pc    = (m_pc + 1) % 65536;
      if (int'(m_word[27:24]) == IMUL && LAT > 1) m_bubbles = LAT - 1;
    end
  endtask

  task automatic apply(input logic rst, input logic stall, input logic br,
                       input logic [15:0] tgt);
    Reset = rst; iStall = stall; iBranchTaken = br; iBranchTarget = tgt;
    @(posedge Clock);
    model_edge(rst, stall, br, tgt);
    #1;
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) rom[a] = 28'h1000000;
    rom[0]        = 28'h0000000;
    rom[1]        = 28'h201000A;
    rom[2]        = 28'h202000A;
    rom[3]        = 28'h0000000;
    rom[4]        = 28'h9030102;
    rom[5]        = 28'h1050505;
    rom[16'h0010] = 28'h3101234;
    rom[16'hFFFF] = 28'h4FFAABB;

    //            rst stall br tgt       vld addr      iaddr     busy op dst    imm
    tbl[0]  = mk(1, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 8'h00, 16'h0000);
    tbl[1]  = mk(0, 0, 0, 16'h0000, 1, 16'h0001, 16'h0000, 0, 0, 8'h00, 16'h0000);
    tbl[2]  = mk(0, 0, 0, 16'h0000, 1, 16'h0002, 16'h0001, 0, 2, 8'h01, 16'h000A);
    tbl[3]  = mk(0, 0, 0, 16'h0000, 1, 16'h0003, 16'h0002, 0, 2, 8'h02, 16'h000A);
    tbl[4]  = mk(0, 1, 0, 16'h0000, 1, 16'h0003, 16'h0002, 0, 2, 8'h02, 16'h000A);
    tbl[5]  = mk(0, 1, 0, 16'h0000, 1, 16'h0003, 16'h0002, 0, 2, 8'h02, 16'h000A);
    tbl[6]  = mk(0, 1, 0, 16'h0000, 1, 16'h0003, 16'h0002, 0, 2, 8'h02, 16'h000A);
    tbl[7]  = mk(0, 0, 0, 16'h0000, 1, 16'h0004, 16'h0003, 0, 0, 8'h00, 16'h0000);
    tbl[8]  = mk(0, 0, 0, 16'h0000, 1, 16'h0005, 16'h0004, 1, 9, 8'h03, 16'h0102);
    tbl[9]  = mk(0, 0, 0, 16'h0000, 0, 16'h0005, 16'h0004, 1, 9, 8'h03, 16'h0102);
    tbl[10] = mk(0, 1, 0, 16'h0000, 0, 16'h0005, 16'h0004, 1, 9, 8'h03, 16'h0102);
    tbl[11] = mk(0, 0, 0, 16'h0000, 0, 16'h0005, 16'h0004, 0, 9, 8'h03, 16'h0102);
    tbl[12] = mk(0, 0, 0, 16'h0000, 1, 16'h0006, 16'h0005, 0, 1, 8'h05, 16'h0505);
    tbl[13] = mk(0, 1, 1, 16'h0010, 0, 16'h0010, 16'h0005, 0, 1, 8'h05, 16'h0505);
    tbl[14] = mk(0, 0, 0, 16'h0000, 1, 16'h0011, 16'h0010, 0, 3, 8'h10, 16'h1234);
    tbl[15] = mk(0, 0, 1, 16'hFFFF, 0, 16'hFFFF, 16'h0010, 0, 3, 8'h10, 16'h1234);
    tbl[16] = mk(0, 0, 0, 16'h0000, 1, 16'h0000, 16'hFFFF, 0, 4, 8'hFF, 16'hAABB);
    tbl[17] = mk(0, 0, 0, 16'h0000, 1, 16'h0001, 16'h0000, 0, 0, 8'h00, 16'h0000);
    tbl[18] = mk(0, 0, 1, 16'h0004, 0, 16'h0004, 16'h0000, 0, 0, 8'h00, 16'h0000);
    tbl[19] = mk(0, 0, 0, 16'h0000, 1, 16'h0005, 16'h0004, 1, 9, 8'h03, 16'h0102);
    tbl[20] = mk(0, 0, 0, 16'h0000, 0, 16'h0005, 16'h0004, 1, 9, 8'h03, 16'h0102);
    tbl[21] = mk(1, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 8'h00, 16'h0000);
    tbl[22] = mk(0, 0, 0, 16'h0000, 1, 16'h0001, 16'h0000, 0, 0, 8'h00, 16'h0000);

    apply(1, 0, 0, 16'h0);
    for (int i = 0; i < 23; i++) begin
      apply(tbl[i].rst, tbl[i].stall, tbl[i].br, tbl[i].tgt);
      chk_all($sformatf("vec%0d", i), tbl[i].vld, tbl[i].addr, tbl[i].iaddr, tbl[i].busy,
              tbl[i].op, tbl[i].dst, tbl[i].imm);
    end

    // Branch arriving mid-IMUL wait cancels the remaining bubbles.
    apply(0, 0, 1, 16'h0004);
    chk_all("hs_br4", 0, 16'h0004, 16'h0000, 0, 0, 8'h00, 16'h0000);
    apply(0, 0, 0, 16'h0000);
    chk_all("hs_imul", 1, 16'h0005, 16'h0004, 1, 9, 8'h03, 16'h0102);
    apply(0, 1, 1, 16'h0010);
    chk_all("hs_brwait", 0, 16'h0010, 16'h0004, 0, 9, 8'h03, 16'h0102);
    apply(0, 0, 0, 16'h0000);
    chk_all("hs_after", 1, 16'h0011, 16'h0010, 0, 3, 8'h10, 16'h1234);

    // Random program and traffic against the model.
    for (int a = 0; a < 65536; a++) begin
      rom[a] = 28'($urandom);
      if ($urandom_range(0, 4) == 0) rom[a][27:24] = 4'(IMUL);
    end
    apply(1, 0, 0, 16'h0);
    for (int c = 0; c < 600; c++) begin
      logic r, s, b;
      logic [15:0] t;
      r = ($urandom_range(0, 59) == 0);
      s = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 9) == 0);
      t = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 63))
                                       : 16'(16'hFFF8 + $urandom_range(0, 7));
      apply(r, s, b, t);
      chk_all($sformatf("rnd%0d", c), m_valid, 16'(m_pc), 16'(m_iaddr), (m_bubbles > 0),
              m_word[27:24], m_word[23:16], m_word[15:0]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
